// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file / scoreboard block.
// Also holds the port-priority helper used to resolve colliding writebacks.
package regfile_scoreboard_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NRD_DEF    = 4;
    localparam int NWR_DEF    = 2;
    localparam int BYPASS_DEF = 1;

    localparam int MAXP = 16;

    typedef logic [MAXP-1:0] port_vec_t;

    // Highest-indexed set bit, or -1 when nothing matches.
    function automatic int prio_idx(input port_vec_t hit);
        int idx;
        idx = -1;
        for (int i = 0; i < MAXP; i++) begin
            if (hit[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback, issue and read-port bundle for the register file scoreboard.
// The master side drives requests; the slave side is the register file.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NWR-1:0]           iss_en;
    logic [NWR-1:0][AW-1:0]   iss_addr;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [AW:0]              busy_cnt;
    logic                     wb_err;

    modport master (
        output wr_en, wr_addr, wr_data,
        output iss_en, iss_addr, rd_addr,
        input  rd_data, rd_busy, busy_cnt, wb_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  iss_en, iss_addr, rd_addr,
        output rd_data, rd_busy, busy_cnt, wb_err
    );

endinterface

// File: rtl/regfile_scoreboard_counter.sv
// Registered popcount of the next pending vector.
// Bit 0 is never pending, so the count stays below N.
module sb_counter #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         pend_next,
    output logic [$clog2(N):0]   count
);
    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next = cnt_next + CW'(pend_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= cnt_next;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with a pending-bit scoreboard.
// Issue marks a destination pending; writeback stores data and clears it.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int NWR    = NWR_DEF,
    parameter int BYPASS = BYPASS_DEF
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int PW = (NWR > 1) ? $clog2(NWR) : 1;

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0][XLEN-1:0] wsel;
    logic [NREGS-1:0]           pend;
    logic [NREGS-1:0]           pend_next;
    logic [NREGS-1:0]           wr_any;
    logic [NREGS-1:0]           iss_any;
    logic                       err_q;
    logic                       err_next;

    // Per-register write winner and issue match; x0 never matches.
    always_comb begin
        port_vec_t hit;
        int        win;
        wr_any  = '0;
        iss_any = '0;
        wsel    = '0;
        for (int r = 1; r < NREGS; r++) begin
            hit = '0;
            for (int i = 0; i < NWR; i++) begin
                hit[i] = bus.wr_en[i] && (bus.wr_addr[i] == AW'(r));
                if (bus.iss_en[i] && (bus.iss_addr[i] == AW'(r)))
                    iss_any[r] = 1'b1;
            end
            win = prio_idx(hit);
            if (win >= 0) begin
                wr_any[r] = 1'b1;
                wsel[r]   = bus.wr_data[PW'(win)];
            end
        end
    end

    assign pend_next = iss_any | (pend & ~wr_any);

    always_comb begin
        err_next = err_q;
        for (int i = 0; i < NWR; i++) begin
            if (bus.wr_en[i] && (bus.wr_addr[i] != '0) &&
                !pend[bus.wr_addr[i]] && !iss_any[bus.wr_addr[i]])
                err_next = 1'b1;
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            a = bus.rd_addr[j];
            if ((BYPASS != 0) && wr_any[a]) begin
                bus.rd_data[j] = wsel[a];
                bus.rd_busy[j] = pend[a] & iss_any[a];
            end else begin
                bus.rd_data[j] = regs[a];
                bus.rd_busy[j] = pend[a];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs  <= '0;
            pend  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_any[r]) regs[r] <= wsel[r];
            end
            pend  <= pend_next;
            err_q <= err_next;
        end
    end

    assign bus.wb_err = err_q;

    sb_counter #(.N(NREGS)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .pend_next (pend_next),
        .count     (bus.busy_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard in two configurations:
// default (bypass, 2 write ports) and BYPASS=0 / 3 ports / 64-bit.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2)) bus_a ();
    regfile_scoreboard_if #(.XLEN(64), .NREGS(32), .NRD(6), .NWR(3)) bus_b ();

    regfile_scoreboard #(
        .XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .BYPASS(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    regfile_scoreboard #(
        .XLEN(64), .NREGS(32), .NRD(6), .NWR(3), .BYPASS(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.wr_en    = '0;
        bus_a.wr_addr  = '0;
        bus_a.wr_data  = '0;
        bus_a.iss_en   = '0;
        bus_a.iss_addr = '0;
        bus_b.wr_en    = '0;
        bus_b.wr_addr  = '0;
        bus_b.wr_data  = '0;
        bus_b.iss_en   = '0;
        bus_b.iss_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        bus_a.rd_addr = '0;
        bus_b.rd_addr = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) bus_a.rd_addr[j] = 5'(j + 1);
        #1;
        n_checks++;
        if (bus_a.busy_cnt !== 6'd0 || bus_a.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a_cnt_err: got cnt=%0d err=%b want 0 0",
                     bus_a.busy_cnt, bus_a.wb_err);
        end
        n_checks++;
        if (bus_a.rd_data !== '0 || bus_a.rd_busy !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_a_read: got data=%h busy=%b want 0",
                     bus_a.rd_data, bus_a.rd_busy);
        end
        n_checks++;
        if (bus_b.busy_cnt !== 6'd0 || bus_b.wb_err !== 1'b0 ||
            bus_b.rd_busy !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_b: got cnt=%0d err=%b busy=%b want 0",
                     bus_b.busy_cnt, bus_b.wb_err, bus_b.rd_busy);
        end
    endtask

    task automatic test_issue_wb();
        bus_a.iss_en      = 2'b01;
        bus_a.iss_addr[0] = 5'd7;
        tick();
        idle();
        bus_a.rd_addr[0] = 5'd7;
        #1;
        n_checks++;
        if (bus_a.rd_busy[0] !== 1'b1 || bus_a.busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL issue_x7: got busy=%b cnt=%0d want 1 1",
                     bus_a.rd_busy[0], bus_a.busy_cnt);
        end
        bus_a.wr_en      = 2'b01;
        bus_a.wr_addr[0] = 5'd7;
        bus_a.wr_data[0] = 32'h12345678;
        #1;
        n_checks++;
        if (bus_a.rd_data[0] !== 32'h12345678 || bus_a.rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_x7_bypass: got data=%h busy=%b want 12345678 0",
                     bus_a.rd_data[0], bus_a.rd_busy[0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_a.busy_cnt !== 6'd0 || bus_a.rd_data[0] !== 32'h12345678 ||
            bus_a.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_x7_after: got cnt=%0d data=%h err=%b want 0 12345678 0",
                     bus_a.busy_cnt, bus_a.rd_data[0], bus_a.wb_err);
        end
    endtask

    task automatic test_issue_wb_same();
        bus_a.iss_en      = 2'b01;
        bus_a.iss_addr[0] = 5'd9;
        tick();
        idle();
        bus_a.iss_en      = 2'b10;
        bus_a.iss_addr[1] = 5'd9;
        bus_a.wr_en       = 2'b01;
        bus_a.wr_addr[0]  = 5'd9;
        bus_a.wr_data[0]  = 32'hDEADBEEF;
        bus_a.rd_addr[1]  = 5'd9;
        #1;
        n_checks++;
        if (bus_a.rd_busy[1] !== 1'b1 || bus_a.rd_data[1] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL same_x9_comb: got busy=%b data=%h want 1 deadbeef",
                     bus_a.rd_busy[1], bus_a.rd_data[1]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_a.rd_busy[1] !== 1'b1 || bus_a.busy_cnt !== 6'd1 ||
            bus_a.rd_data[1] !== 32'hDEADBEEF || bus_a.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL same_x9_after: got busy=%b cnt=%0d data=%h err=%b want 1 1 deadbeef 0",
                     bus_a.rd_busy[1], bus_a.busy_cnt, bus_a.rd_data[1], bus_a.wb_err);
        end
        bus_a.wr_en      = 2'b10;
        bus_a.wr_addr[1] = 5'd9;
        bus_a.wr_data[1] = 32'h00000009;
        tick();
        idle();
    endtask

    task automatic test_same_addr();
        bus_a.iss_en      = 2'b10;
        bus_a.iss_addr[1] = 5'd5;
        tick();
        idle();
        bus_a.wr_en      = 2'b11;
        bus_a.wr_addr[0] = 5'd5;
        bus_a.wr_addr[1] = 5'd5;
        bus_a.wr_data[0] = 32'hAAAA0000;
        bus_a.wr_data[1] = 32'h5555FFFF;
        bus_a.rd_addr[2] = 5'd5;
        #1;
        n_checks++;
        if (bus_a.rd_data[2] !== 32'h5555FFFF) begin
            n_fail++;
            $display("FAIL dup_wr_x5_bypass: got %h want 5555ffff",
                     bus_a.rd_data[2]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_a.rd_data[2] !== 32'h5555FFFF || bus_a.busy_cnt !== 6'd0 ||
            bus_a.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_wr_x5_after: got data=%h cnt=%0d err=%b want 5555ffff 0 0",
                     bus_a.rd_data[2], bus_a.busy_cnt, bus_a.wb_err);
        end
    endtask

    task automatic test_wb_err();
        bus_a.wr_en      = 2'b10;
        bus_a.wr_addr[1] = 5'd0;
        bus_a.wr_data[1] = 32'hFFFFFFFF;
        bus_a.iss_en      = 2'b01;
        bus_a.iss_addr[0] = 5'd0;
        bus_a.rd_addr[3]  = 5'd0;
        #1;
        n_checks++;
        if (bus_a.rd_data[3] !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_comb: got %h want 0", bus_a.rd_data[3]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_a.rd_data[3] !== 32'd0 || bus_a.rd_busy[3] !== 1'b0 ||
            bus_a.wb_err !== 1'b0 || bus_a.busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL x0_after: got data=%h busy=%b err=%b cnt=%0d want 0 0 0 0",
                     bus_a.rd_data[3], bus_a.rd_busy[3], bus_a.wb_err, bus_a.busy_cnt);
        end
        bus_a.wr_en      = 2'b01;
        bus_a.wr_addr[0] = 5'd3;
        bus_a.wr_data[0] = 32'h00000001;
        #1;
        n_checks++;
        if (bus_a.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_err_early: got %b want 0", bus_a.wb_err);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_a.wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_err_set: got %b want 1", bus_a.wb_err);
        end
        tick();
        tick();
        n_checks++;
        if (bus_a.wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_err_sticky: got %b want 1", bus_a.wb_err);
        end
    endtask

    task automatic test_reset_all();
        for (int r = 1; r < 32; r += 2) begin
            bus_a.iss_en      = (r + 1 < 32) ? 2'b11 : 2'b01;
            bus_a.iss_addr[0] = 5'(r);
            bus_a.iss_addr[1] = 5'(r + 1);
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (bus_a.busy_cnt !== 6'd31) begin
            n_fail++;
            $display("FAIL issue_all_cnt: got %0d want 31", bus_a.busy_cnt);
        end
        bus_a.iss_en      = 2'b11;
        bus_a.iss_addr[0] = 5'd1;
        bus_a.iss_addr[1] = 5'd31;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_a.busy_cnt !== 6'd31) begin
            n_fail++;
            $display("FAIL dup_issue_cnt: got %0d want 31", bus_a.busy_cnt);
        end
        rst              = 1'b1;
        bus_a.wr_en      = 2'b11;
        bus_a.wr_addr[0] = 5'd1;
        bus_a.wr_addr[1] = 5'd2;
        bus_a.wr_data[0] = 32'hCAFEBABE;
        bus_a.wr_data[1] = 32'h0BADF00D;
        bus_a.iss_en      = 2'b01;
        bus_a.iss_addr[0] = 5'd4;
        tick();
        rst = 1'b0;
        idle();
        bus_a.rd_addr[0] = 5'd1;
        bus_a.rd_addr[1] = 5'd2;
        bus_a.rd_addr[2] = 5'd3;
        bus_a.rd_addr[3] = 5'd4;
        #1;
        n_checks++;
        if (bus_a.rd_data !== '0 || bus_a.rd_busy !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_all_read: got data=%h busy=%b want 0",
                     bus_a.rd_data, bus_a.rd_busy);
        end
        n_checks++;
        if (bus_a.busy_cnt !== 6'd0 || bus_a.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_all_state: got cnt=%0d err=%b want 0 0",
                     bus_a.busy_cnt, bus_a.wb_err);
        end
    endtask

    task automatic test_b_same_addr();
        bus_b.iss_en      = 3'b100;
        bus_b.iss_addr[2] = 5'd5;
        tick();
        idle();
        bus_b.wr_en      = 3'b011;
        bus_b.wr_addr[0] = 5'd5;
        bus_b.wr_addr[1] = 5'd5;
        bus_b.wr_data[0] = 64'hAAAA0000_AAAA0000;
        bus_b.wr_data[1] = 64'h5555FFFF_5555FFFF;
        bus_b.rd_addr[5] = 5'd5;
        #1;
        n_checks++;
        if (bus_b.rd_data[5] !== 64'd0 || bus_b.rd_busy[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL b_dup_wr_comb: got data=%h busy=%b want 0 1",
                     bus_b.rd_data[5], bus_b.rd_busy[5]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_b.rd_data[5] !== 64'h5555FFFF_5555FFFF ||
            bus_b.busy_cnt !== 6'd0 || bus_b.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_dup_wr_after: got data=%h cnt=%0d err=%b want 5555ffff5555ffff 0 0",
                     bus_b.rd_data[5], bus_b.busy_cnt, bus_b.wb_err);
        end
    endtask

    task automatic test_b_issue_wb();
        bus_b.iss_en      = 3'b100;
        bus_b.iss_addr[2] = 5'd7;
        tick();
        idle();
        bus_b.rd_addr[4] = 5'd7;
        #1;
        n_checks++;
        if (bus_b.rd_busy[4] !== 1'b1 || bus_b.busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL b_issue_x7: got busy=%b cnt=%0d want 1 1",
                     bus_b.rd_busy[4], bus_b.busy_cnt);
        end
        bus_b.wr_en      = 3'b100;
        bus_b.wr_addr[2] = 5'd7;
        bus_b.wr_data[2] = 64'h12345678;
        #1;
        n_checks++;
        if (bus_b.rd_data[4] !== 64'd0 || bus_b.rd_busy[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL b_wb_x7_comb: got data=%h busy=%b want 0 1",
                     bus_b.rd_data[4], bus_b.rd_busy[4]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_b.rd_data[4] !== 64'h12345678 || bus_b.rd_busy[4] !== 1'b0 ||
            bus_b.busy_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL b_wb_x7_after: got data=%h busy=%b cnt=%0d want 12345678 0 0",
                     bus_b.rd_data[4], bus_b.rd_busy[4], bus_b.busy_cnt);
        end
    endtask

    task automatic test_b_same_cycle();
        bus_b.iss_en      = 3'b001;
        bus_b.iss_addr[0] = 5'd9;
        tick();
        idle();
        bus_b.iss_en      = 3'b010;
        bus_b.iss_addr[1] = 5'd9;
        bus_b.wr_en       = 3'b001;
        bus_b.wr_addr[0]  = 5'd9;
        bus_b.wr_data[0]  = 64'hDEADBEEF_CAFEF00D;
        bus_b.rd_addr[3]  = 5'd9;
        #1;
        n_checks++;
        if (bus_b.rd_data[3] !== 64'd0 || bus_b.rd_busy[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL b_same_x9_comb: got data=%h busy=%b want 0 1",
                     bus_b.rd_data[3], bus_b.rd_busy[3]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus_b.rd_data[3] !== 64'hDEADBEEF_CAFEF00D || bus_b.rd_busy[3] !== 1'b1 ||
            bus_b.busy_cnt !== 6'd1 || bus_b.wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_same_x9_after: got data=%h busy=%b cnt=%0d err=%b want deadbeefcafef00d 1 1 0",
                     bus_b.rd_data[3], bus_b.rd_busy[3], bus_b.busy_cnt, bus_b.wb_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_issue_wb();
        test_issue_wb_same();
        test_same_addr();
        test_wb_err();
        test_reset_all();
        test_b_same_addr();
        test_b_issue_wb();
        test_b_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL take these parameters: XLEN, 32, data width.
REQ-002 The block SHALL take these parameters: NREGS, 32, register count (power of two, >=2); AW = clog2(NREGS).
REQ-003 The block SHALL take these parameters: NRD, 4, read ports; NWR, 2, write/writeback ports (also the issue-port count).
REQ-004 The block SHALL take these parameters: BYPASS, 1, when 1 same-cycle writes are forwarded to read data.
REQ-005 The block SHALL have these ports: clk  in  1  clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have these ports: wr_en  in  NWR  per-port writeback enable; wr_addr  in  NWR x AW  destination; wr_data  in  NWR x XLEN  data.
REQ-007 The block SHALL have these ports: iss_en  in  NWR  per-port issue enable (marks destination pending); iss_addr  in  NWR x AW  destination.
REQ-008 The block SHALL have these ports: rd_addr  in  NRD x AW  source; rd_data  out  NRD x XLEN  read data; rd_busy  out  NRD  source pending flag.
REQ-009 The block SHALL have these ports: busy_cnt  out  AW+1  number of pending registers; wb_err  out  1  sticky: writeback to a non-pending register.

Function
REQ-010 Register 0 SHALL read as zero, SHALL never be written and SHALL never be pending.
REQ-011 Writes SHALL commit on the rising clk edge when wr_en[i]=1 and wr_addr[i]!=0.
REQ-012 If several enabled write ports target the same address, the highest-indexed port SHALL win and the others SHALL be dropped.
REQ-013 rd_data SHALL be combinational from rd_addr (zero-cycle read latency).
REQ-014 With BYPASS=1, a read of an address being written this cycle SHALL return the winning write data (REQ-012 priority); with BYPASS=0 it SHALL return the pre-edge value.
REQ-015 The pending bit of register r SHALL be set at the edge when any iss_en[i]=1 with iss_addr[i]=r.
REQ-016 The pending bit of register r SHALL be cleared at the edge when any wr_en[i]=1 with wr_addr[i]=r.
REQ-017 If r is both issued and written back in the same cycle, set SHALL win (r stays pending).
REQ-018 rd_busy[j] SHALL equal the registered pending bit of rd_addr[j]; with BYPASS=1 it SHALL read 0 if that register is written back this cycle and not re-issued.
REQ-019 busy_cnt SHALL be a registered count of pending bits, updated in the same cycle as the bits and never exceeding NREGS-1.
REQ-020 wb_err SHALL be set one cycle after any enabled writeback to a non-zero register whose pending bit is 0 and which is not issued that cycle; it SHALL stay set until rst.
REQ-021 Duplicate issue to an already pending register SHALL keep it pending and SHALL NOT change busy_cnt.
REQ-022 Writeback and issue targeting register 0 SHALL be ignored and SHALL NOT set wb_err.

Reset
REQ-023 While rst=1 at an edge, all registers SHALL become 0, all pending bits 0, busy_cnt 0 and wb_err 0.
REQ-024 Writes and issues presented in a reset cycle SHALL be discarded.
REQ-025 rd_data SHALL read 0 and rd_busy SHALL read 0 in the cycle after reset.

Structure
REQ-026 Default parameter values and a port-index priority helper (highest enabled match) SHALL live in the shared core package.
REQ-027 The popcount/next-count logic SHALL be one sub-module, sb_counter, instantiated once.
REQ-028 The storage array and pending vector SHALL be flat flops with no memory macro; all sequential logic SHALL be in the clk domain only.

Verification
REQ-029 The bench SHALL cover: wr port0 (x5,0xAAAA0000) and port1 (x5,0x5555FFFF) in the same cycle -> x5 reads 0x5555FFFF on the next cycle.
REQ-030 The bench SHALL cover: issue x7, next cycle read x7 -> rd_busy=1, busy_cnt=1; writeback x7=0x12345678 -> same-cycle read (BYPASS=1) gives 0x12345678 with busy 0, and busy_cnt=0 after the edge.
REQ-031 The bench SHALL cover: same cycle, issue x9 on port1 and writeback x9 on port0 while x9 is pending -> x9 stays pending, busy_cnt unchanged, data updated.
REQ-032 The bench SHALL cover: writeback x3 while x3 is not pending -> wb_err=1 next cycle and held; write x0=0xFFFFFFFF -> x0 reads 0 with no wb_err change.
REQ-033 The bench SHALL cover: issue x1..x31 then assert rst with concurrent writes -> all reads 0, busy_cnt=0, wb_err=0 after the edge.
REQ-034 The bench SHALL cover: rerun REQ-029 to REQ-031 with BYPASS=0, NRD=6, NWR=3, XLEN=64 -> same results except that same-cycle reads return pre-edge values.
